// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end of the risc_v core. Generates the program
// counter, reads a word-addressed synchronous instruction memory (`ram`,
// preloadable hierarchically, never written by this block), and presents
// fetched instructions to decode through a valid/ready handshake backed by a
// 2-entry buffer. A redirect from execute flushes the buffer and drops any
// read that is returning in the same cycle.
//
// Ports
//   clk            : single clock, all state on the rising edge
//   rst            : asynchronous assert, active-low reset (0 = reset)
//   redirect_valid : execute requests a PC change this cycle
//   redirect_pc    : redirect target byte address, bits [1:0] ignored
//   id_ready       : decode accepts an instruction this cycle
//   instr_valid    : instr/instr_pc hold a valid instruction
//   instr          : instruction at buffer head (NOP when not valid)
//   instr_pc       : byte address of instr (0 when not valid)
//   fetch_pc       : address of the next memory read to be issued
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned                INSTR_ADDRESS_WIDTH = 6,
    parameter int unsigned                CPU_DATA_WIDTH      = 32,
    parameter logic [CPU_DATA_WIDTH-1:0]  RESET_PC            = {CPU_DATA_WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [CPU_DATA_WIDTH-1:0] redirect_pc,
    input  logic                      id_ready,
    output logic                      instr_valid,
    output logic [CPU_DATA_WIDTH-1:0] instr,
    output logic [CPU_DATA_WIDTH-1:0] instr_pc,
    output logic [CPU_DATA_WIDTH-1:0] fetch_pc
);

    localparam int unsigned DEPTH = 2 ** INSTR_ADDRESS_WIDTH;
    localparam logic [CPU_DATA_WIDTH-1:0] NOP_INSTR = CPU_DATA_WIDTH'(32'h0000_0013);
    localparam logic [CPU_DATA_WIDTH-1:0] PC_STEP   = CPU_DATA_WIDTH'(32'd4);
    localparam logic [CPU_DATA_WIDTH-1:0] ZERO_WORD = {CPU_DATA_WIDTH{1'b0}};

    // Instruction memory: contents come from outside (preload), no reset.
    logic [CPU_DATA_WIDTH-1:0] ram [DEPTH];

    // Architectural state
    logic [CPU_DATA_WIDTH-1:0]      pc_r;
    logic                           inflight_r;
    logic [CPU_DATA_WIDTH-1:0]      inflight_pc_r;
    logic [CPU_DATA_WIDTH-1:0]      rdata_r;
    logic [CPU_DATA_WIDTH-1:0]      buf_instr_r [2];
    logic [CPU_DATA_WIDTH-1:0]      buf_pc_r    [2];
    logic [1:0]                     count_r;

    // Registered outputs
    logic                           instr_valid_r;
    logic [CPU_DATA_WIDTH-1:0]      instr_r;
    logic [CPU_DATA_WIDTH-1:0]      instr_pc_r;

    // Next-state / combinational helpers
    logic [CPU_DATA_WIDTH-1:0]      pc_s;
    logic [CPU_DATA_WIDTH-1:0]      redirect_target_s;
    logic [CPU_DATA_WIDTH-1:0]      buf_instr_s [2];
    logic [CPU_DATA_WIDTH-1:0]      buf_pc_s    [2];
    logic [1:0]                     count_s;
    logic [2:0]                     occ_s;
    logic                           pop_s;
    logic                           push_s;
    logic                           issue_s;
    logic [INSTR_ADDRESS_WIDTH-1:0] rd_idx_s;

    // The two low redirect bits are deliberately dropped (word alignment).
    logic                           unused_ok_s;
    assign unused_ok_s = ^redirect_pc[1:0];

    // Word index into ram; upper pc bits fall away so the index wraps.
    assign rd_idx_s = pc_r[INSTR_ADDRESS_WIDTH+1:2];

    // Handshake, issue decision, buffer and pc next-state.
    always_comb begin
        pop_s             = (count_r != 2'd0) && id_ready;
        push_s            = inflight_r;
        // Occupancy after this cycle's pop: buffered entries plus the read
        // that is returning. A new read may only issue if that leaves room,
        // which keeps buffered + outstanding at most 2 and the buffer safe.
        occ_s             = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s           = !redirect_valid && (occ_s <= 3'd1);
        redirect_target_s = {redirect_pc[CPU_DATA_WIDTH-1:2], 2'b00};

        buf_instr_s = buf_instr_r;
        buf_pc_s    = buf_pc_r;
        count_s     = count_r;

        if (redirect_valid) begin
            // Flush dominates: a simultaneous pop is still consumed by
            // decode, the returning read is simply not written.
            count_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b01: begin
                    buf_instr_s[0] = buf_instr_r[1];
                    buf_pc_s[0]    = buf_pc_r[1];
                    count_s        = count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        buf_instr_s[0] = rdata_r;
                        buf_pc_s[0]    = inflight_pc_r;
                    end else begin
                        buf_instr_s[1] = rdata_r;
                        buf_pc_s[1]    = inflight_pc_r;
                    end
                    count_s = count_r + 2'd1;
                end
                2'b11: begin
                    // Head leaves; the returning word lands behind whatever
                    // remains, so with one entry it becomes the new head.
                    if (count_r == 2'd1) begin
                        buf_instr_s[0] = rdata_r;
                        buf_pc_s[0]    = inflight_pc_r;
                    end else begin
                        buf_instr_s[0] = buf_instr_r[1];
                        buf_pc_s[0]    = buf_pc_r[1];
                        buf_instr_s[1] = rdata_r;
                        buf_pc_s[1]    = inflight_pc_r;
                    end
                    count_s = count_r;
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end

        if (redirect_valid) begin
            pc_s = redirect_target_s;
        end else if (issue_s) begin
            pc_s = pc_r + PC_STEP;
        end else begin
            pc_s = pc_r;
        end
    end

    // Synchronous memory read: data is available the cycle after issue.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            rdata_r <= ram[rd_idx_s];
        end
    end

    // Pipeline state, buffer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r           <= RESET_PC;
            inflight_r     <= 1'b0;
            inflight_pc_r  <= ZERO_WORD;
            buf_instr_r[0] <= NOP_INSTR;
            buf_instr_r[1] <= NOP_INSTR;
            buf_pc_r[0]    <= ZERO_WORD;
            buf_pc_r[1]    <= ZERO_WORD;
            count_r        <= 2'd0;
            instr_valid_r  <= 1'b0;
            instr_r        <= NOP_INSTR;
            instr_pc_r     <= ZERO_WORD;
        end else begin
            pc_r          <= pc_s;
            inflight_r    <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
            buf_instr_r   <= buf_instr_s;
            buf_pc_r      <= buf_pc_s;
            count_r       <= count_s;
            // Outputs are built from next state so they line up with count_r.
            instr_valid_r <= (count_s != 2'd0);
            instr_r       <= (count_s != 2'd0) ? buf_instr_s[0] : NOP_INSTR;
            instr_pc_r    <= (count_s != 2'd0) ? buf_pc_s[0]    : ZERO_WORD;
        end
    end

    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign fetch_pc    = pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. The reference model is a queue of issued
// fetches tagged with their issue cycle: an entry is visible to decode two
// cycles after issue, a redirect empties the queue, and a new fetch is allowed
// while at most one entry remains after decode's pop. Every cycle all four
// outputs are compared against that model, and directed scenarios add fixed
// expectations (first valid cycle, backpressure hold, redirect, wrap, reset).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          AW    = 6;
    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;

    fetch_unit #(
        .INSTR_ADDRESS_WIDTH (AW),
        .CPU_DATA_WIDTH      (DW),
        .RESET_PC            (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] pc;
        int          icyc;
    } item_t;

    logic [31:0] mem_model [DEPTH];
    item_t       pend_q [$];
    logic [31:0] model_pc;
    logic [31:0] acc_pc [$];
    logic [31:0] acc_data [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic model_valid();
        return (pend_q.size() > 0) && (pend_q[0].icyc <= cyc - 2);
    endfunction

    task automatic preload(input bit identity);
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = identity ? 32'(i) : $urandom;
            mem_model[i] = v;
            dut.ram[i]   = v;
        end
    endtask

    task automatic compare_outputs();
        logic        v;
        logic [31:0] hp;
        logic [31:0] hd;
        v  = model_valid();
        hp = 32'h0;
        hd = NOP;
        if (v) begin
            hp = pend_q[0].pc;
            hd = mem_model[hp[AW+1:2]];
        end
        check_eq("instr_valid", 32'(instr_valid), 32'(v));
        check_eq("instr",       instr,            hd);
        check_eq("instr_pc",    instr_pc,         hp);
        check_eq("fetch_pc",    fetch_pc,         model_pc);
    endtask

    // One clock: check outputs, drive inputs, advance the model, clock.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic  pop;
        item_t it;
        compare_outputs();
        if (instr_valid && rdy) begin
            acc_pc.push_back(instr_pc);
            acc_data.push_back(instr);
        end
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        pop = model_valid() && rdy;
        if (pop) void'(pend_q.pop_front());
        if (rv) begin
            pend_q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end else if (pend_q.size() <= 1) begin
            it.pc   = model_pc;
            it.icyc = cyc;
            pend_q.push_back(it);
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset between clock edges, check immediate effect, release later.
    task automatic async_reset(input bit reload);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_valid",    32'(instr_valid), 32'h0);
        check_eq("rst_fetch_pc", fetch_pc,         RPC);
        check_eq("rst_instr",    instr,            NOP);
        check_eq("rst_instr_pc", instr_pc,         32'h0);
        if (reload) preload(1'b0);
        pend_q.delete();
        model_pc = RPC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [31:0] exp_wpc [3];
        logic [31:0] exp_wd  [3];
        bit          seen;
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;

        exp_wpc[0] = 32'h0000_00F8; exp_wpc[1] = 32'h0000_00FC; exp_wpc[2] = 32'h0000_0100;
        exp_wd[0]  = 32'd62;        exp_wd[1]  = 32'd63;        exp_wd[2]  = 32'd0;

        preload(1'b1);
        model_pc = RPC;
        repeat (2) @(negedge clk);
        check_eq("reset_valid",    32'(instr_valid), 32'h0);
        check_eq("reset_instr",    instr,            NOP);
        check_eq("reset_instr_pc", instr_pc,         32'h0);
        check_eq("reset_fetch_pc", fetch_pc,         RPC);
        rst = 1'b1;
        cyc = 0;

        // Sequential fetch, then decode stalls in cycles 3..7.
        for (int i = 0; i < 16; i++) begin
            if (cyc == 1) check_eq("not_yet_valid", 32'(instr_valid), 32'h0);
            if (cyc == 2) begin
                check_eq("first_valid", 32'(instr_valid), 32'h1);
                check_eq("first_pc",    instr_pc,         32'h0);
            end
            if (cyc >= 3 && cyc <= 8) begin
                check_eq("bp_hold_pc",    instr_pc, 32'h4);
                check_eq("bp_hold_instr", instr,    32'h1);
            end
            step(1'b0, 32'h0, !(cyc >= 3 && cyc <= 7));
        end

        // Redirect to 0x2B in cycle 5.
        async_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            if (cyc == 6 || cyc == 7) check_eq("redir_bubble", 32'(instr_valid), 32'h0);
            if (cyc == 8) begin
                check_eq("redir_pc",    instr_pc, 32'h28);
                check_eq("redir_instr", instr,    32'd10);
            end
            step(cyc == 5, 32'h0000_002B, 1'b1);
        end

        // Fill the buffer, then pop and redirect together.
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
        check_eq("full_before_flush", 32'(instr_valid), 32'h1);
        step(1'b1, 32'h0000_0080, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!seen && instr_valid) begin
                seen = 1'b1;
                check_eq("flush_target_pc", instr_pc, 32'h80);
            end
            step(1'b0, 32'h0, 1'b1);
        end
        check_eq("flush_target_seen", 32'(seen), 32'h1);

        // Index wrap-around past the end of the 64-word memory.
        step(1'b1, 32'h0000_00F8, 1'b1);
        acc_pc.delete();
        acc_data.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("wrap_pc",   (i < acc_pc.size())   ? acc_pc[i]   : 32'hDEAD_BEEF, exp_wpc[i]);
            check_eq("wrap_data", (i < acc_data.size()) ? acc_data[i] : 32'hDEAD_BEEF, exp_wd[i]);
        end

        // 32-bit pc rollover, and back-to-back redirects.
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0040, 1'b1);
        step(1'b1, 32'h0000_0060, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Async reset mid-stream with fresh random memory contents.
        async_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            if (cyc == 2) begin
                check_eq("restart_valid", 32'(instr_valid), 32'h1);
                check_eq("restart_pc",    instr_pc,         RPC);
            end
            step(1'b0, 32'h0, 1'b1);
        end

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) async_reset(1'b1);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            step(rv, rpc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
